// File: rtl/neuron_layer_seq_if.sv
// Result stream from the layer sequencer to the next layer's input buffer.
// Latency: n/a, pure signal bundle.
// Backpressure: out_valid holds data/idx stable until out_ready is seen high.
interface neuron_layer_seq_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 2
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic [IDX_W-1:0]        out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/neuron_layer_seq.sv
// Time-multiplexes one shared combinational 3-input neuron across N_NEURONS neurons of a layer.
// Latency: first result 4 cycles after start is accepted, then 4 cycles per neuron when unstalled.
// Backpressure: each cycle out_ready is low in OUT adds one cycle; no weight reads while stalled.
module neuron_layer_seq #(
    parameter int WIDTH     = 32,
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a_in_1,
    input  logic signed [WIDTH-1:0] a_in_2,
    input  logic signed [WIDTH-1:0] a_in_3,
    output logic                    busy,
    output logic                    done,
    output logic                    w_rd_en,
    output logic [IDX_W-1:0]        w_addr,
    input  logic [4*WIDTH-1:0]      w_data,
    output logic signed [WIDTH-1:0] n_a_1,
    output logic signed [WIDTH-1:0] n_a_2,
    output logic signed [WIDTH-1:0] n_a_3,
    output logic signed [WIDTH-1:0] n_w_1,
    output logic signed [WIDTH-1:0] n_w_2,
    output logic signed [WIDTH-1:0] n_w_3,
    output logic signed [WIDTH-1:0] n_b,
    input  logic signed [WIDTH-1:0] n_y,
    neuron_layer_seq_if.master      out_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EVAL,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    // Activation vector latched on start; isolates the pass from later a_in_* changes.
    logic signed [WIDTH-1:0] act_1_q, act_1_d;
    logic signed [WIDTH-1:0] act_2_q, act_2_d;
    logic signed [WIDTH-1:0] act_3_q, act_3_d;
    logic signed [WIDTH-1:0] n_a_1_q, n_a_1_d;
    logic signed [WIDTH-1:0] n_a_2_q, n_a_2_d;
    logic signed [WIDTH-1:0] n_a_3_q, n_a_3_d;
    logic signed [WIDTH-1:0] n_w_1_q, n_w_1_d;
    logic signed [WIDTH-1:0] n_w_2_q, n_w_2_d;
    logic signed [WIDTH-1:0] n_w_3_q, n_w_3_d;
    logic signed [WIDTH-1:0] n_b_q, n_b_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;

    // Next-state and datapath capture: each state owns exactly one register group.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        act_1_d    = act_1_q;
        act_2_d    = act_2_q;
        act_3_d    = act_3_q;
        n_a_1_d    = n_a_1_q;
        n_a_2_d    = n_a_2_q;
        n_a_3_d    = n_a_3_q;
        n_w_1_d    = n_w_1_q;
        n_w_2_d    = n_w_2_q;
        n_w_3_d    = n_w_3_q;
        n_b_d      = n_b_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    act_1_d = a_in_1;
                    act_2_d = a_in_2;
                    act_3_d = a_in_3;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Read data arrives this cycle; layout is {b, w_3, w_2, w_1} MSB to LSB.
                n_w_1_d = w_data[WIDTH-1:0];
                n_w_2_d = w_data[2*WIDTH-1:WIDTH];
                n_w_3_d = w_data[3*WIDTH-1:2*WIDTH];
                n_b_d   = w_data[4*WIDTH-1:3*WIDTH];
                n_a_1_d = act_1_q;
                n_a_2_d = act_2_q;
                n_a_3_d = act_3_q;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                // Operands have been stable a full cycle; the neuron output has settled.
                out_data_d = n_y;
                out_idx_d  = idx_q;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_if.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            act_1_q    <= '0;
            act_2_q    <= '0;
            act_3_q    <= '0;
            n_a_1_q    <= '0;
            n_a_2_q    <= '0;
            n_a_3_q    <= '0;
            n_w_1_q    <= '0;
            n_w_2_q    <= '0;
            n_w_3_q    <= '0;
            n_b_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            act_1_q    <= act_1_d;
            act_2_q    <= act_2_d;
            act_3_q    <= act_3_d;
            n_a_1_q    <= n_a_1_d;
            n_a_2_q    <= n_a_2_d;
            n_a_3_q    <= n_a_3_d;
            n_w_1_q    <= n_w_1_d;
            n_w_2_q    <= n_w_2_d;
            n_w_3_q    <= n_w_3_d;
            n_b_q      <= n_b_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // Control outputs are pure state decodes so they are glitch-free and reset with the FSM.
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign w_rd_en          = (state_q == S_FETCH);
    assign w_addr           = idx_q;
    assign out_if.out_valid = (state_q == S_OUT);
    assign out_if.out_data  = out_data_q;
    assign out_if.out_idx   = out_idx_q;
    assign n_a_1            = n_a_1_q;
    assign n_a_2            = n_a_2_q;
    assign n_a_3            = n_a_3_q;
    assign n_w_1            = n_w_1_q;
    assign n_w_2            = n_w_2_q;
    assign n_w_3            = n_w_3_q;
    assign n_b              = n_b_q;

endmodule
